multicycle_control: RTL

Main control FSM for the multicycle datapath. Decodes the 4-bit instruction opcode over fetch/decode/execute/memory/writeback states and drives every datapath strobe plus the 3-bit `ALUOp` consumed by `ALU_Control`. Memory accesses stall on a `mem_ready` handshake.

---
 rtl/multicycle_control.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle datapath: sequences fetch/decode/execute/memory/writeback
// and drives every datapath strobe, with memory accesses stalling on mem_ready.
module multicycle_control (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    output logic [2:0] ALUOp,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNE,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       halted,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_RTYPE_EX  = 4'd3,
        S_SHIFT_EX  = 4'd4,
        S_ALU_WB    = 4'd5,
        S_MEM_ADDR  = 4'd6,
        S_LOAD_MEM  = 4'd7,
        S_LOAD_WB   = 4'd8,
        S_STORE_MEM = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_IMM_EX    = 4'd12,
        S_IMM_WB    = 4'd13,
        S_HALT      = 4'd14
    } state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       fetch;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       halted;
    } ctrl_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_opcode;
    logic [3:0] w_opcode_next;
    logic       r_illegal;
    logic       w_illegal_next;
    ctrl_t      r_ctrl;

    // Moore strobes for a state; op is the latched opcode that state will see.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_op    = 3'd2;
                c.fetch     = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_op    = 3'd2;
            end
            S_RTYPE_EX: c.alu_src_a = 1'b1;
            S_SHIFT_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 3'd1;
            end
            S_ALU_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = 3'd2;
            end
            S_LOAD_MEM: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_LOAD_WB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_STORE_MEM: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 3'd3;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.branch_ne     = (op == 4'h5);
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            S_IMM_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                case (op)
                    4'h8:    c.alu_op = 3'd4;
                    4'h9:    c.alu_op = 3'd5;
                    4'hA:    c.alu_op = 3'd6;
                    default: c.alu_op = 3'd2;
                endcase
            end
            S_IMM_WB: c.reg_write = 1'b1;
            S_HALT:   c.halted    = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_state_next   = r_state;
        w_opcode_next  = r_opcode;
        w_illegal_next = r_illegal;
        case (r_state)
            S_RESET: w_state_next = S_FETCH;
            S_FETCH: if (mem_ready) w_state_next = S_DECODE;
            S_DECODE: begin
                w_opcode_next = opcode;
                case (opcode)
                    4'h0:                      w_state_next = S_RTYPE_EX;
                    4'h1:                      w_state_next = S_SHIFT_EX;
                    4'h2, 4'h3:                w_state_next = S_MEM_ADDR;
                    4'h4, 4'h5:                w_state_next = S_BRANCH;
                    4'h6:                      w_state_next = S_JUMP;
                    4'h7, 4'h8, 4'h9, 4'hA:    w_state_next = S_IMM_EX;
                    4'hF:                      w_state_next = S_HALT;
                    default: begin
                        w_illegal_next = 1'b1;
                        w_state_next   = S_FETCH;
                    end
                endcase
            end
            S_RTYPE_EX, S_SHIFT_EX: w_state_next = S_ALU_WB;
            S_MEM_ADDR:  w_state_next = (r_opcode == 4'h2) ? S_LOAD_MEM : S_STORE_MEM;
            S_LOAD_MEM:  if (mem_ready) w_state_next = S_LOAD_WB;
            S_STORE_MEM: if (mem_ready) w_state_next = S_FETCH;
            S_IMM_EX:    w_state_next = S_IMM_WB;
            S_ALU_WB, S_LOAD_WB, S_BRANCH, S_JUMP, S_IMM_WB: w_state_next = S_FETCH;
            S_HALT:      w_state_next = S_HALT;
            default:     w_state_next = S_RESET;
        endcase
    end

    // Strobes are registered alongside the state they belong to.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_RESET;
            r_opcode  <= 4'h0;
            r_illegal <= 1'b0;
            r_ctrl    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_opcode  <= w_opcode_next;
            r_illegal <= w_illegal_next;
            r_ctrl    <= decode_ctrl(w_state_next, w_opcode_next);
        end
    end

    // IR/PC update in FETCH only fires on the cycle memory delivers the instruction.
    assign IRWrite     = r_ctrl.fetch & mem_ready;
    assign PCWrite     = r_ctrl.pc_write | (r_ctrl.fetch & mem_ready);
    assign ALUOp       = r_ctrl.alu_op;
    assign PCWriteCond = r_ctrl.pc_write_cond;
    assign BranchNE    = r_ctrl.branch_ne;
    assign PCSource    = r_ctrl.pc_source;
    assign IorD        = r_ctrl.i_or_d;
    assign MemRead     = r_ctrl.mem_read;
    assign MemWrite    = r_ctrl.mem_write;
    assign ALUSrcA     = r_ctrl.alu_src_a;
    assign ALUSrcB     = r_ctrl.alu_src_b;
    assign RegDst      = r_ctrl.reg_dst;
    assign MemtoReg    = r_ctrl.mem_to_reg;
    assign RegWrite    = r_ctrl.reg_write;
    assign halted      = r_ctrl.halted;
    assign illegal     = r_illegal;
    assign state       = r_state;

endmodule
